// File: rtl/vc_input_buffer.sv
// vc_input_buffer: multi-VC input buffer for a wormhole router port.
// NUM_VC independent circular FIFOs with first-word fall-through read of the
// selected VC and per-VC on/off flow control with hysteresis.
// Optional feature macro: VC_BUF_ERR_EN enables sticky overflow/underflow flags;
// without it the error ports are tied to 0.

// Per-VC circular FIFO; wr_i/rd_i arrive already qualified by the top level.
module vc_input_buffer_lane #(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int OFF_THRESH = 14,
  parameter int ON_THRESH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  output logic [FLIT_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  buffer_on_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, empty_q, buffer_on_q, buffer_on_d;

  // Next pointers (explicit wrap for non-power-of-two depth), count and hysteresis
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    buffer_on_d = buffer_on_q;
    if (wr_i) wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (rd_i) rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    case ({wr_i, rd_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d >= CNT_W'(OFF_THRESH))     buffer_on_d = 1'b0;
    else if (count_d <= CNT_W'(ON_THRESH)) buffer_on_d = 1'b1;
  end

  // Control state; flags are registered from the next count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      buffer_on_q <= 1'b1;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CNT_W'(DEPTH));
      empty_q     <= (count_d == '0);
      buffer_on_q <= buffer_on_d;
    end
  end

  // Storage is deliberately not reset; reset ignores the write
  always_ff @(posedge clk_i) begin
    if (wr_i && !rst_i) mem_q[wptr_q] <= flit_i;
  end

  assign head_o      = mem_q[rptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign buffer_on_o = buffer_on_q;
endmodule

module vc_input_buffer #(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int NUM_VC     = 4,
  parameter int OFF_THRESH = 14,
  parameter int ON_THRESH  = 2,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FLIT_WIDTH-1:0] flit_in_i,
  input  logic                  push_i,
  input  logic [VC_W-1:0]       push_vc_i,
  input  logic                  pop_i,
  input  logic [VC_W-1:0]       pop_vc_i,
  output logic [FLIT_WIDTH-1:0] flit_out_o,
  output logic [NUM_VC-1:0]     full_o,
  output logic [NUM_VC-1:0]     empty_o,
  output logic [NUM_VC-1:0]     buffer_on_o,
  output logic                  err_overflow_o,
  output logic                  err_underflow_o
);
  logic [NUM_VC-1:0][FLIT_WIDTH-1:0] head;
  logic [NUM_VC-1:0]                 wr, rd;
  logic                              same_pop, push_ok, pop_ok;

  // Accept qualification; a full VC still takes a push when it is popped same cycle
  always_comb begin
    pop_ok   = pop_i && !empty_o[pop_vc_i];
    same_pop = pop_ok && (push_vc_i == pop_vc_i);
    push_ok  = push_i && (!full_o[push_vc_i] || same_pop);
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr[v] = push_ok && (push_vc_i == VC_W'(v));
    assign rd[v] = pop_ok  && (pop_vc_i  == VC_W'(v));
    vc_input_buffer_lane #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .DEPTH      (DEPTH),
      .OFF_THRESH (OFF_THRESH),
      .ON_THRESH  (ON_THRESH)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_i        (wr[v]),
      .rd_i        (rd[v]),
      .flit_i      (flit_in_i),
      .head_o      (head[v]),
      .full_o      (full_o[v]),
      .empty_o     (empty_o[v]),
      .buffer_on_o (buffer_on_o[v])
    );
  end

  assign flit_out_o = head[pop_vc_i];

`ifdef VC_BUF_ERR_EN
  logic ovf_q, unf_q;
  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_i && !push_ok) ovf_q <= 1'b1;
      if (pop_i  && !pop_ok)  unf_q <= 1'b1;
    end
  end
  assign err_overflow_o  = ovf_q;
  assign err_underflow_o = unf_q;
`else
  assign err_overflow_o  = 1'b0;
  assign err_underflow_o = 1'b0;
`endif
endmodule
